// File: rtl/alu_operand_stage.sv
// ALU operand stage: resolves register operands through the EX/WB bypass paths,
// selects the X/Y sources and holds one decoded instruction for the ALU behind a
// valid/ready handshake, with a load-use interlock on the upstream side.
module alu_operand_stage #(
    parameter int STALL_CNT_W = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_flush,

    input  logic                   i_valid,
    output logic                   o_ready,

    input  logic [31:0]            i_pc,
    input  logic [31:0]            i_rs1_data,
    input  logic [31:0]            i_rs2_data,
    input  logic [31:0]            i_imm,
    input  logic [4:0]             i_rs1_addr,
    input  logic [4:0]             i_rs2_addr,
    input  logic [4:0]             i_rd_addr,
    input  logic [2:0]             i_funct3,
    input  logic                   i_funct7b5,
    input  logic                   i_src_a_pc,
    input  logic                   i_src_b_imm,

    input  logic                   i_ex_fwd_valid,
    input  logic [4:0]             i_ex_fwd_rd,
    input  logic [31:0]            i_ex_fwd_data,
    input  logic                   i_wb_fwd_valid,
    input  logic [4:0]             i_wb_fwd_rd,
    input  logic [31:0]            i_wb_fwd_data,

    input  logic                   i_ld_busy,
    input  logic [4:0]             i_ld_rd,

    output logic                   o_valid,
    input  logic                   i_ready,
    output logic [2:0]             o_op,
    output logic                   o_op2,
    output logic [31:0]            o_x,
    output logic [31:0]            o_y,
    output logic [4:0]             o_rd_addr,
    output logic [31:0]            o_pc,
    output logic [STALL_CNT_W-1:0] o_stall_cnt
);

    localparam int NSRC = 2;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t                 state_reg;
    state_t                 state_next;
    logic [2:0]             op_reg;
    logic                   op2_reg;
    logic [31:0]            x_reg;
    logic [31:0]            y_reg;
    logic [4:0]             rd_reg;
    logic [31:0]            pc_reg;
    logic [STALL_CNT_W-1:0] stall_reg;

    logic [4:0]             rs_addr   [NSRC];
    logic [31:0]            rs_data   [NSRC];
    logic [31:0]            rs_val    [NSRC];
    logic [NSRC-1:0]        src_bypass;
    logic [NSRC-1:0]        ld_hit;

    logic                   hazard;
    logic                   capture;
    logic                   consume;
    logic [31:0]            x_next;
    logic [31:0]            y_next;
    logic                   op2_next;

    assign rs_addr[0]    = i_rs1_addr;
    assign rs_addr[1]    = i_rs2_addr;
    assign rs_data[0]    = i_rs1_data;
    assign rs_data[1]    = i_rs2_data;
    // A source replaced by pc/imm neither needs forwarding nor can cause a load-use stall.
    assign src_bypass[0] = i_src_a_pc;
    assign src_bypass[1] = i_src_b_imm;

    genvar gi;
    generate
        for (gi = 0; gi < NSRC; gi++) begin : g_src
            logic ex_hit;
            logic wb_hit;

            assign ex_hit = i_ex_fwd_valid && (i_ex_fwd_rd != 5'd0) && (i_ex_fwd_rd == rs_addr[gi]);
            assign wb_hit = i_wb_fwd_valid && (i_wb_fwd_rd != 5'd0) && (i_wb_fwd_rd == rs_addr[gi]);

            // x0 is hardwired zero; the younger EX result wins over WB.
            assign rs_val[gi] = (rs_addr[gi] == 5'd0) ? 32'd0         :
                                ex_hit                ? i_ex_fwd_data :
                                wb_hit                ? i_wb_fwd_data :
                                                        rs_data[gi];

            assign ld_hit[gi] = (i_ld_rd == rs_addr[gi]) && !src_bypass[gi];
        end
    endgenerate

    assign hazard  = i_valid && i_ld_busy && (i_ld_rd != 5'd0) && (|ld_hit);

    assign o_valid = (state_reg == FULL);
    assign o_ready = (!o_valid || i_ready) && !hazard;
    assign capture = i_valid && o_ready && !i_flush;
    assign consume = o_valid && i_ready;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            EMPTY: if (capture) state_next = FULL;
            FULL:  if (consume && !capture) state_next = EMPTY;
            default: state_next = EMPTY;
        endcase
        if (i_flush) state_next = EMPTY;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg <= EMPTY;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        x_next   = i_src_a_pc  ? i_pc  : rs_val[0];
        y_next   = i_src_b_imm ? i_imm : rs_val[1];
        op2_next = 1'b0;
        // Shifts only use the low five bits of the amount.
        if (i_funct3 == 3'b001 || i_funct3 == 3'b101) begin
            y_next = {27'd0, y_next[4:0]};
        end
        case (i_funct3)
            3'b000:  op2_next = i_funct7b5 && !i_src_b_imm;
            3'b101:  op2_next = i_funct7b5;
            default: op2_next = 1'b0;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            op_reg  <= 3'd0;
            op2_reg <= 1'b0;
            x_reg   <= 32'd0;
            y_reg   <= 32'd0;
            rd_reg  <= 5'd0;
            pc_reg  <= 32'd0;
        end else if (capture) begin
            op_reg  <= i_funct3;
            op2_reg <= op2_next;
            x_reg   <= x_next;
            y_reg   <= y_next;
            rd_reg  <= i_rd_addr;
            pc_reg  <= i_pc;
        end
    end

    // Back-pressure counter: saturates rather than wrapping so long stalls stay visible.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            stall_reg <= '0;
        end else if (o_valid && !i_ready && (stall_reg != {STALL_CNT_W{1'b1}})) begin
            stall_reg <= stall_reg + 1'b1;
        end
    end

    assign o_op        = op_reg;
    assign o_op2       = op2_reg;
    assign o_x         = x_reg;
    assign o_y         = y_reg;
    assign o_rd_addr   = rd_reg;
    assign o_pc        = pc_reg;
    assign o_stall_cnt = stall_reg;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Bench for alu_operand_stage: directed scenarios plus randomized traffic checked
// against a behavioural model of the operand stage.
module tb_alu_operand_stage;

    localparam int SW   = 4;
    localparam int SMAX = (1 << SW) - 1;

    logic          i_clk, i_rst, i_flush, i_valid, o_ready;
    logic [31:0]   i_pc, i_rs1_data, i_rs2_data, i_imm;
    logic [4:0]    i_rs1_addr, i_rs2_addr, i_rd_addr;
    logic [2:0]    i_funct3;
    logic          i_funct7b5, i_src_a_pc, i_src_b_imm;
    logic          i_ex_fwd_valid, i_wb_fwd_valid;
    logic [4:0]    i_ex_fwd_rd, i_wb_fwd_rd;
    logic [31:0]   i_ex_fwd_data, i_wb_fwd_data;
    logic          i_ld_busy;
    logic [4:0]    i_ld_rd;
    logic          o_valid, i_ready;
    logic [2:0]    o_op;
    logic          o_op2;
    logic [31:0]   o_x, o_y, o_pc;
    logic [4:0]    o_rd_addr;
    logic [SW-1:0] o_stall_cnt;

    int checks = 0;
    int errors = 0;

    // Behavioural model of the visible stage contents
    logic        m_valid;
    logic [2:0]  m_op;
    logic        m_op2;
    logic [31:0] m_x, m_y, m_pc;
    logic [4:0]  m_rd;
    int          m_stall;
    logic        m_cap;

    alu_operand_stage #(.STALL_CNT_W(SW)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_flush(i_flush),
        .i_valid(i_valid), .o_ready(o_ready),
        .i_pc(i_pc), .i_rs1_data(i_rs1_data), .i_rs2_data(i_rs2_data), .i_imm(i_imm),
        .i_rs1_addr(i_rs1_addr), .i_rs2_addr(i_rs2_addr), .i_rd_addr(i_rd_addr),
        .i_funct3(i_funct3), .i_funct7b5(i_funct7b5),
        .i_src_a_pc(i_src_a_pc), .i_src_b_imm(i_src_b_imm),
        .i_ex_fwd_valid(i_ex_fwd_valid), .i_ex_fwd_rd(i_ex_fwd_rd), .i_ex_fwd_data(i_ex_fwd_data),
        .i_wb_fwd_valid(i_wb_fwd_valid), .i_wb_fwd_rd(i_wb_fwd_rd), .i_wb_fwd_data(i_wb_fwd_data),
        .i_ld_busy(i_ld_busy), .i_ld_rd(i_ld_rd),
        .o_valid(o_valid), .i_ready(i_ready),
        .o_op(o_op), .o_op2(o_op2), .o_x(o_x), .o_y(o_y),
        .o_rd_addr(o_rd_addr), .o_pc(o_pc), .o_stall_cnt(o_stall_cnt)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    function automatic logic [31:0] ref_operand(input logic [4:0] a, input logic [31:0] d);
        if (a == 5'd0) return 32'd0;
        if (i_ex_fwd_valid && i_ex_fwd_rd == a) return i_ex_fwd_data;
        if (i_wb_fwd_valid && i_wb_fwd_rd == a) return i_wb_fwd_data;
        return d;
    endfunction

    function automatic logic ref_hazard();
        return i_valid && i_ld_busy && (i_ld_rd != 5'd0) &&
               ((i_ld_rd == i_rs1_addr && !i_src_a_pc) || (i_ld_rd == i_rs2_addr && !i_src_b_imm));
    endfunction

    function automatic logic ref_ready();
        return (!m_valid || i_ready) && !ref_hazard();
    endfunction

    task automatic model_reset();
        m_valid = 0; m_op = 0; m_op2 = 0; m_x = 0; m_y = 0; m_pc = 0; m_rd = 0; m_stall = 0; m_cap = 0;
    endtask

    // Advance the model by one rising edge using the inputs currently applied.
    task automatic model_update();
        logic [31:0] y;
        m_cap = 0;
        if (i_rst) begin
            model_reset();
            return;
        end
        m_cap = i_valid && ref_ready() && !i_flush;
        if (m_valid && !i_ready) m_stall = (m_stall >= SMAX) ? SMAX : m_stall + 1;
        if (m_cap) begin
            m_op  = i_funct3;
            m_x   = i_src_a_pc ? i_pc : ref_operand(i_rs1_addr, i_rs1_data);
            y     = i_src_b_imm ? i_imm : ref_operand(i_rs2_addr, i_rs2_data);
            m_y   = (i_funct3 == 3'b001 || i_funct3 == 3'b101) ? (y % 32) : y;
            m_op2 = (i_funct3 == 3'b000) ? (i_funct7b5 && !i_src_b_imm) :
                    (i_funct3 == 3'b101) ? i_funct7b5 : 1'b0;
            m_rd  = i_rd_addr;
            m_pc  = i_pc;
        end
        if (i_flush)                   m_valid = 0;
        else if (m_cap)                m_valid = 1;
        else if (m_valid && i_ready)   m_valid = 0;
    endtask

    task automatic tick();
        model_update();
        @(posedge i_clk);
        #1;
        if (m_cap) $display("txn pc=%h op=%0d op2=%0d x=%h y=%h rd=%0d", m_pc, m_op, m_op2, m_x, m_y, m_rd);
    endtask

    task automatic idle_inputs();
        i_flush = 0; i_valid = 0; i_pc = 0; i_rs1_data = 0; i_rs2_data = 0; i_imm = 0;
        i_rs1_addr = 0; i_rs2_addr = 0; i_rd_addr = 0; i_funct3 = 0; i_funct7b5 = 0;
        i_src_a_pc = 0; i_src_b_imm = 0; i_ex_fwd_valid = 0; i_ex_fwd_rd = 0; i_ex_fwd_data = 0;
        i_wb_fwd_valid = 0; i_wb_fwd_rd = 0; i_wb_fwd_data = 0; i_ld_busy = 0; i_ld_rd = 0;
        i_ready = 1;
    endtask

    task automatic set_instr(input logic [2:0] f3, input logic f7b5, input logic a_pc, input logic b_imm,
                             input logic [4:0] r1a, input logic [31:0] r1d,
                             input logic [4:0] r2a, input logic [31:0] r2d,
                             input logic [31:0] imm, input logic [4:0] rd, input logic [31:0] pc);
        i_valid = 1; i_funct3 = f3; i_funct7b5 = f7b5; i_src_a_pc = a_pc; i_src_b_imm = b_imm;
        i_rs1_addr = r1a; i_rs1_data = r1d; i_rs2_addr = r2a; i_rs2_data = r2d;
        i_imm = imm; i_rd_addr = rd; i_pc = pc;
    endtask

    task automatic apply_reset();
        idle_inputs();
        i_rst = 1;
        model_reset();
        @(posedge i_clk);
        #1;
        i_rst = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        i_rst = 1;
        model_reset();
        set_instr(3'b000, 0, 0, 0, 5'd3, 32'h1, 5'd4, 32'h2, 0, 5'd1, 32'h40);
        i_ld_busy = 1; i_ld_rd = 5'd3;
        #1;
        checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_hazard got %b exp 0", o_ready); end
        i_ld_busy = 0;
        #1;
        checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_clear got %b exp 1", o_ready); end
        tick();
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_no_capture got %b exp 0", o_valid); end
        checks++;
        if ({o_op, o_op2, o_x, o_y, o_rd_addr, o_pc, o_stall_cnt} !== '0) begin
            errors++; $display("FAIL reset_outputs got x=%h y=%h pc=%h op=%0d rd=%0d st=%0d exp all 0",
                               o_x, o_y, o_pc, o_op, o_rd_addr, o_stall_cnt);
        end
        i_rst = 0;
        idle_inputs();
    endtask

    task automatic test_basic();
        set_instr(3'b000, 1, 0, 0, 5'd1, 32'd10, 5'd2, 32'd3, 0, 5'd9, 32'h100);
        i_ready = 1;
        #1;
        checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL basic_ready got %b exp 1", o_ready); end
        tick();
        checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %b exp 1", o_valid); end
        checks++; if (o_op !== 3'b000 || o_op2 !== 1'b1) begin errors++; $display("FAIL basic_op got %0d/%0d exp 0/1", o_op, o_op2); end
        checks++; if (o_x !== 32'd10 || o_y !== 32'd3) begin errors++; $display("FAIL basic_xy got %h/%h exp a/3", o_x, o_y); end
        checks++; if (o_rd_addr !== 5'd9 || o_pc !== 32'h100) begin errors++; $display("FAIL basic_rd_pc got %0d/%h exp 9/100", o_rd_addr, o_pc); end
        idle_inputs();
        tick();
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL basic_drain got %b exp 0", o_valid); end
        checks++; if (o_x !== 32'd10) begin errors++; $display("FAIL basic_data_hold got %h exp a", o_x); end
    endtask

    task automatic test_forward();
        set_instr(3'b000, 0, 0, 0, 5'd5, 32'h11, 5'd6, 32'h22, 0, 5'd2, 32'h200);
        i_ex_fwd_valid = 1; i_ex_fwd_rd = 5'd5; i_ex_fwd_data = 32'hAA;
        i_wb_fwd_valid = 1; i_wb_fwd_rd = 5'd5; i_wb_fwd_data = 32'hBB;
        tick();
        checks++; if (o_x !== 32'hAA) begin errors++; $display("FAIL fwd_ex_priority got %h exp aa", o_x); end
        checks++; if (o_y !== 32'h22) begin errors++; $display("FAIL fwd_no_match got %h exp 22", o_y); end
        i_ex_fwd_rd = 5'd4;
        tick();
        checks++; if (o_x !== 32'hBB) begin errors++; $display("FAIL fwd_wb got %h exp bb", o_x); end
        i_rs1_addr = 5'd0; i_rs1_data = 32'h55; i_ex_fwd_rd = 5'd0; i_wb_fwd_rd = 5'd0;
        tick();
        checks++; if (o_x !== 32'h0) begin errors++; $display("FAIL fwd_x0 got %h exp 0", o_x); end
        checks++; if (o_y !== 32'h22) begin errors++; $display("FAIL fwd_rd0_ignored got %h exp 22", o_y); end
        idle_inputs();
    endtask

    task automatic test_shift_imm();
        set_instr(3'b101, 1, 0, 1, 5'd1, 32'h8000_0000, 5'd2, 32'h7, 32'h0000_0423, 5'd3, 32'h300);
        tick();
        checks++; if (o_y !== 32'h3 || o_op2 !== 1'b1 || o_op !== 3'b101) begin
            errors++; $display("FAIL srai got y=%h op2=%0d op=%0d exp 3/1/5", o_y, o_op2, o_op); end
        set_instr(3'b001, 1, 0, 0, 5'd1, 32'h1, 5'd2, 32'hFFFF_FFE7, 0, 5'd3, 32'h304);
        tick();
        checks++; if (o_y !== 32'h7 || o_op2 !== 1'b0) begin
            errors++; $display("FAIL sll_mask got y=%h op2=%0d exp 7/0", o_y, o_op2); end
        set_instr(3'b000, 1, 1, 1, 5'd1, 32'h1, 5'd2, 32'h2, 32'hFFFF_FFFF, 5'd3, 32'h308);
        tick();
        checks++; if (o_op2 !== 1'b0 || o_x !== 32'h308 || o_y !== 32'hFFFF_FFFF) begin
            errors++; $display("FAIL addi_pc got op2=%0d x=%h y=%h exp 0/308/ffffffff", o_op2, o_x, o_y); end
        idle_inputs();
        tick();
    endtask

    task automatic test_stall_flush();
        apply_reset();
        set_instr(3'b100, 0, 0, 0, 5'd8, 32'hDEAD_BEEF, 5'd9, 32'h1234, 0, 5'd12, 32'h400);
        tick();
        idle_inputs();
        i_ready = 0;
        repeat (4) tick();
        checks++; if (o_stall_cnt !== SW'(4)) begin errors++; $display("FAIL stall_cnt4 got %0d exp 4", o_stall_cnt); end
        checks++; if (o_valid !== 1'b1 || o_x !== 32'hDEAD_BEEF || o_y !== 32'h1234 || o_pc !== 32'h400 || o_rd_addr !== 5'd12) begin
            errors++; $display("FAIL stall_hold got v=%b x=%h y=%h pc=%h rd=%0d", o_valid, o_x, o_y, o_pc, o_rd_addr); end
        set_instr(3'b000, 0, 0, 0, 5'd1, 32'h99, 5'd2, 32'h98, 0, 5'd1, 32'h500);
        #1;
        checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL stall_ready got %b exp 0", o_ready); end
        i_valid = 0;
        repeat (SMAX - 4 + 2) tick();
        checks++; if (o_stall_cnt !== SW'(SMAX)) begin errors++; $display("FAIL stall_saturate got %0d exp %0d", o_stall_cnt, SMAX); end
        i_flush = 1; i_ready = 0;
        tick();
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL flush_clears got %b exp 0", o_valid); end
        checks++; if (o_stall_cnt !== SW'(SMAX)) begin errors++; $display("FAIL stall_kept got %0d exp %0d", o_stall_cnt, SMAX); end
        set_instr(3'b000, 0, 0, 0, 5'd1, 32'h77, 5'd2, 32'h76, 0, 5'd1, 32'h600);
        i_flush = 1; i_ready = 1;
        tick();
        checks++; if (o_valid !== 1'b0 || o_x !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL flush_beats_capture got v=%b x=%h exp 0/deadbeef", o_valid, o_x); end
        idle_inputs();
    endtask

    task automatic test_hazard();
        set_instr(3'b000, 0, 0, 0, 5'd3, 32'h30, 5'd7, 32'h70, 32'h5, 5'd4, 32'h700);
        i_ld_busy = 1; i_ld_rd = 5'd7; i_ready = 1;
        #1;
        checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL hazard_ready got %b exp 0", o_ready); end
        i_src_b_imm = 1;
        #1;
        checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL hazard_imm_bypass got %b exp 1", o_ready); end
        i_src_b_imm = 0;
        tick();
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL hazard_no_capture got %b exp 0", o_valid); end
        i_ld_busy = 0;
        #1;
        checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL hazard_release got %b exp 1", o_ready); end
        tick();
        checks++; if (o_valid !== 1'b1 || o_y !== 32'h70 || o_x !== 32'h30) begin
            errors++; $display("FAIL hazard_capture got v=%b x=%h y=%h exp 1/30/70", o_valid, o_x, o_y); end
    endtask

    task automatic test_back_to_back();
        i_ld_busy = 0; i_ready = 1;
        for (int k = 0; k < 6; k++) begin
            set_instr(3'b110, 0, 0, 0, 5'd1, 32'(k * 3 + 1), 5'd2, 32'(k), 0, 5'(k + 1), 32'(32'h800 + k * 4));
            #1;
            checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d] got %b exp 1", k, o_ready); end
            tick();
            checks++; if (o_valid !== 1'b1 || o_x !== 32'(k * 3 + 1) || o_rd_addr !== 5'(k + 1)) begin
                errors++; $display("FAIL b2b[%0d] got v=%b x=%h rd=%0d exp 1/%h/%0d", k, o_valid, o_x, o_rd_addr, k * 3 + 1, k + 1); end
        end
    endtask

    task automatic test_async_reset();
        idle_inputs();
        i_ready = 0;
        #3;
        i_rst = 1;
        model_reset();
        #1;
        checks++;
        if ({o_valid, o_op, o_op2, o_x, o_y, o_rd_addr, o_pc, o_stall_cnt} !== '0) begin
            errors++; $display("FAIL async_reset got v=%b x=%h y=%h pc=%h st=%0d exp all 0", o_valid, o_x, o_y, o_pc, o_stall_cnt);
        end
        set_instr(3'b111, 0, 0, 0, 5'd1, 32'hF0, 5'd2, 32'h0F, 0, 5'd5, 32'h900);
        i_ready = 1;
        tick();
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL async_reset_hold got %b exp 0", o_valid); end
        #2;
        i_rst = 0;
        tick();
        checks++; if (o_valid !== 1'b1 || o_x !== 32'hF0 || o_pc !== 32'h900) begin
            errors++; $display("FAIL post_reset_capture got v=%b x=%h pc=%h exp 1/f0/900", o_valid, o_x, o_pc); end
        idle_inputs();
    endtask

    task automatic test_random();
        for (int n = 0; n < 500; n++) begin
            i_valid        = ($urandom_range(0, 3) != 0);
            i_ready        = ($urandom_range(0, 4) < 3);
            i_flush        = ($urandom_range(0, 11) == 0);
            i_pc           = $urandom;
            i_rs1_data     = $urandom;
            i_rs2_data     = $urandom;
            i_imm          = $urandom;
            i_rs1_addr     = 5'($urandom_range(0, 7));
            i_rs2_addr     = 5'($urandom_range(0, 7));
            i_rd_addr      = 5'($urandom_range(0, 31));
            i_funct3       = 3'($urandom_range(0, 7));
            i_funct7b5     = 1'($urandom_range(0, 1));
            i_src_a_pc     = ($urandom_range(0, 3) == 0);
            i_src_b_imm    = ($urandom_range(0, 2) == 0);
            i_ex_fwd_valid = 1'($urandom_range(0, 1));
            i_ex_fwd_rd    = 5'($urandom_range(0, 7));
            i_ex_fwd_data  = $urandom;
            i_wb_fwd_valid = 1'($urandom_range(0, 1));
            i_wb_fwd_rd    = 5'($urandom_range(0, 7));
            i_wb_fwd_data  = $urandom;
            i_ld_busy      = ($urandom_range(0, 3) == 0);
            i_ld_rd        = 5'($urandom_range(0, 7));
            #1;
            checks++; if (o_ready !== ref_ready()) begin errors++; $display("FAIL rand_ready[%0d] got %b exp %b", n, o_ready, ref_ready()); end
            tick();
            checks++; if (o_valid !== m_valid) begin errors++; $display("FAIL rand_valid[%0d] got %b exp %b", n, o_valid, m_valid); end
            checks++; if (o_x !== m_x) begin errors++; $display("FAIL rand_x[%0d] got %h exp %h", n, o_x, m_x); end
            checks++; if (o_y !== m_y) begin errors++; $display("FAIL rand_y[%0d] got %h exp %h", n, o_y, m_y); end
            checks++; if (o_op !== m_op || o_op2 !== m_op2) begin
                errors++; $display("FAIL rand_op[%0d] got %0d/%0d exp %0d/%0d", n, o_op, o_op2, m_op, m_op2); end
            checks++; if (o_rd_addr !== m_rd || o_pc !== m_pc) begin
                errors++; $display("FAIL rand_rd_pc[%0d] got %0d/%h exp %0d/%h", n, o_rd_addr, o_pc, m_rd, m_pc); end
            checks++; if (o_stall_cnt !== SW'(m_stall)) begin
                errors++; $display("FAIL rand_stall[%0d] got %0d exp %0d", n, o_stall_cnt, m_stall); end
        end
        idle_inputs();
    endtask

    initial begin
        i_rst = 1;
        idle_inputs();
        model_reset();
        test_reset();
        test_basic();
        test_forward();
        test_shift_imm();
        test_stall_flush();
        test_hazard();
        test_back_to_back();
        test_async_reset();
        apply_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
